// File: rtl/fifo_drain_serializer.sv
// fifo_drain_serializer
//   Drains a synchronous FIFO one word at a time and shifts each word out on
//   a single UART-style line: start bit (0), DATA_W data bits LSB first,
//   optional even-parity bit, stop bit (1). Every bit lasts CLKS_PER_BIT clks.
//
// Ports
//   clk           system clock, rising edge
//   rst_n         asynchronous active-low reset
//   ena           enable, only looked at while idle
//   fifo_empty    FIFO empty flag, only looked at while idle
//   fifo_rd_data  FIFO read data, valid the cycle after fifo_rd_en
//   fifo_rd_en    one-cycle pop strobe per word
//   tx_out        registered serial line, idles high
//   busy          high whenever a word is being fetched or sent
//   tx_done       one-cycle pulse in the idle cycle that follows a stop bit
//   word_count    completed frames, wraps modulo 2^CNT_W
module fifo_drain_serializer #(
   parameter int DATA_W       = 4,
   parameter int CLKS_PER_BIT = 4,
   parameter int PARITY_EN    = 0,
   parameter int CNT_W        = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ena,
   input  logic              fifo_empty,
   input  logic [DATA_W-1:0] fifo_rd_data,
   output logic              fifo_rd_en,
   output logic              tx_out,
   output logic              busy,
   output logic              tx_done,
   output logic [CNT_W-1:0]  word_count
);

   // Counter widths stay at least one bit so CLKS_PER_BIT=1 / DATA_W=1 build.
   localparam int DIV_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKS_PER_BIT - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_POP    = 3'd1;
   localparam logic [2:0] S_WAIT   = 3'd2;
   localparam logic [2:0] S_START  = 3'd3;
   localparam logic [2:0] S_DATA   = 3'd4;
   localparam logic [2:0] S_PARITY = 3'd5;
   localparam logic [2:0] S_STOP   = 3'd6;

   logic [2:0]        state;
   logic [DIV_W-1:0]  div_cnt;
   logic [BIT_W-1:0]  bit_cnt;
   logic [DATA_W-1:0] shreg;
   logic              par_bit;
   logic              bit_end;

   function automatic logic even_parity(input logic [DATA_W-1:0] word);
      return ^word;
   endfunction

   assign bit_end    = (div_cnt == DIV_LAST);
   assign fifo_rd_en = (state == S_POP);
   assign busy       = (state != S_IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         div_cnt    <= '0;
         bit_cnt    <= '0;
         shreg      <= '0;
         par_bit    <= 1'b0;
         tx_out     <= 1'b1;
         tx_done    <= 1'b0;
         word_count <= '0;
      end else begin
         tx_done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (ena && !fifo_empty) state <= S_POP;
            end
            S_POP: begin
               state <= S_WAIT;
            end
            // Read data is valid now; parity is taken from the captured word
            // so later FIFO activity cannot disturb it.
            S_WAIT: begin
               shreg   <= fifo_rd_data;
               par_bit <= even_parity(fifo_rd_data);
               tx_out  <= 1'b0;
               div_cnt <= '0;
               state   <= S_START;
            end
            S_START: begin
               if (bit_end) begin
                  div_cnt <= '0;
                  bit_cnt <= '0;
                  tx_out  <= shreg[0];
                  shreg   <= shreg >> 1;
                  state   <= S_DATA;
               end else begin
                  div_cnt <= div_cnt + DIV_W'(1);
               end
            end
            S_DATA: begin
               if (bit_end) begin
                  div_cnt <= '0;
                  if (bit_cnt == BIT_LAST) begin
                     if (PARITY_EN != 0) begin
                        tx_out <= par_bit;
                        state  <= S_PARITY;
                     end else begin
                        tx_out <= 1'b1;
                        state  <= S_STOP;
                     end
                  end else begin
                     tx_out  <= shreg[0];
                     shreg   <= shreg >> 1;
                     bit_cnt <= bit_cnt + BIT_W'(1);
                  end
               end else begin
                  div_cnt <= div_cnt + DIV_W'(1);
               end
            end
            S_PARITY: begin
               if (bit_end) begin
                  div_cnt <= '0;
                  tx_out  <= 1'b1;
                  state   <= S_STOP;
               end else begin
                  div_cnt <= div_cnt + DIV_W'(1);
               end
            end
            S_STOP: begin
               if (bit_end) begin
                  div_cnt    <= '0;
                  tx_done    <= 1'b1;
                  word_count <= word_count + CNT_W'(1);
                  state      <= S_IDLE;
               end else begin
                  div_cnt <= div_cnt + DIV_W'(1);
               end
            end
            default: begin
               state   <= S_IDLE;
               div_cnt <= '0;
               tx_out  <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_drain_serializer.sv
// Bench for fifo_drain_serializer. Instance 0 uses the default parameters,
// instance 1 has parity enabled and a 2-bit word counter so wrap is reachable.
module tb_fifo_drain_serializer;

   localparam int C = 4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [1:0] ena;
   logic [1:0] fifo_empty;
   logic [3:0] rd_data0, rd_data1;
   logic [1:0] rd_en, tx_out, busy, tx_done;
   logic [7:0] wc_out0;
   logic [1:0] wc_out1;

   int n_tests = 0;
   int n_fail  = 0;
   int ncyc    = 0;
   int rd_cnt[2], rd_dbl[2], rd_cyc[2], empty_low[2], hold[2], wc_exp[2];
   bit prev_rd[2];
   logic [3:0] q0[$];
   logic [3:0] q1[$];

   fifo_drain_serializer #(.DATA_W(4), .CLKS_PER_BIT(C), .PARITY_EN(0), .CNT_W(8)) u_dut (
      .clk(clk), .rst_n(rst_n), .ena(ena[0]), .fifo_empty(fifo_empty[0]),
      .fifo_rd_data(rd_data0), .fifo_rd_en(rd_en[0]), .tx_out(tx_out[0]),
      .busy(busy[0]), .tx_done(tx_done[0]), .word_count(wc_out0));

   fifo_drain_serializer #(.DATA_W(4), .CLKS_PER_BIT(C), .PARITY_EN(1), .CNT_W(2)) u_dut_p (
      .clk(clk), .rst_n(rst_n), .ena(ena[1]), .fifo_empty(fifo_empty[1]),
      .fifo_rd_data(rd_data1), .fifo_rd_en(rd_en[1]), .tx_out(tx_out[1]),
      .busy(busy[1]), .tx_done(tx_done[1]), .word_count(wc_out1));

   always #5 clk = ~clk;

   // FIFO models and pop monitor in one process so bookkeeping is race-free.
   // Read data is random except from the pop until the start bit is under way.
   initial begin
      logic pe;
      fifo_empty = 2'b11;
      rd_data0 = '0;
      rd_data1 = '0;
      for (int i = 0; i < 2; i++) begin
         rd_cnt[i] = 0; rd_dbl[i] = 0; rd_cyc[i] = 0; empty_low[i] = 0;
         hold[i] = 0; prev_rd[i] = 0;
      end
      forever begin
         @(negedge clk);
         ncyc++;
         for (int i = 0; i < 2; i++) begin
            if (rd_en[i]) begin
               rd_cnt[i]++;
               rd_cyc[i] = ncyc;
               if (prev_rd[i]) rd_dbl[i]++;
            end
            prev_rd[i] = rd_en[i];
         end
         if (rd_en[0] && q0.size() > 0) begin rd_data0 = q0.pop_front(); hold[0] = 2; end
         else if (hold[0] > 0) hold[0]--;
         else rd_data0 = 4'($urandom);
         pe = fifo_empty[0];
         fifo_empty[0] = (q0.size() == 0);
         if (pe && !fifo_empty[0]) empty_low[0] = ncyc;
         if (rd_en[1] && q1.size() > 0) begin rd_data1 = q1.pop_front(); hold[1] = 2; end
         else if (hold[1] > 0) hold[1]--;
         else rd_data1 = 4'($urandom);
         pe = fifo_empty[1];
         fifo_empty[1] = (q1.size() == 0);
         if (pe && !fifo_empty[1]) empty_low[1] = ncyc;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   function automatic int wcount(input int i);
      return (i == 0) ? int'(wc_out0) : int'(wc_out1);
   endfunction

   // Reference frame: start 0, data LSB first, even parity on instance 1,
   // stop 1, each bit C cycles, then tx_done with the counter advanced.
   task automatic check_frame(input int i, input logic [3:0] w, input string nm,
                              input int drop_at, output int t_fall, output int t_done);
      bit   eb[$];
      bit   seen, bad;
      logic act;
      eb.push_back(1'b0);
      for (int b = 0; b < 4; b++) eb.push_back(w[b]);
      if (i == 1) eb.push_back(^w);
      eb.push_back(1'b1);
      seen = 0;
      for (int k = 0; k < 200 && !seen; k++) begin
         if (tx_out[i] === 1'b0) seen = 1;
         else tick();
      end
      n_tests++;
      t_fall = ncyc;
      t_done = ncyc;
      if (!seen) begin
         n_fail++;
         $display("FAIL %s start: tx_out=%b never fell, required 0", nm, tx_out[i]);
         return;
      end
      for (int b = 0; b < eb.size(); b++) begin
         bad = 0;
         act = eb[b];
         for (int c = 0; c < C; c++) begin
            if (!bad && (tx_out[i] !== eb[b] || busy[i] !== 1'b1 || tx_done[i] !== 1'b0)) begin
               bad = 1;
               act = tx_out[i];
            end
            if (b * C + c == drop_at) ena[i] = 1'b0;
            tick();
         end
         n_tests++;
         if (bad) begin
            n_fail++;
            $display("FAIL %s bit%0d: tx_out=%b busy=%b, required tx_out=%b busy=1 held %0d cycles",
                     nm, b, act, busy[i], eb[b], C);
         end
      end
      t_done = ncyc;
      wc_exp[i] = (wc_exp[i] + 1) % ((i == 0) ? 256 : 4);
      n_tests++;
      if (tx_done[i] !== 1'b1 || busy[i] !== 1'b0 || wcount(i) != wc_exp[i]) begin
         n_fail++;
         $display("FAIL %s done: tx_done=%b busy=%b word_count=%0d, required 1/0/%0d at %0d cycles after fall",
                  nm, tx_done[i], busy[i], wcount(i), wc_exp[i], eb.size() * C);
      end
      tick();
      n_tests++;
      if (tx_done[i] !== 1'b0) begin
         n_fail++;
         $display("FAIL %s done_width: tx_done=%b one cycle later, required 0", nm, tx_done[i]);
      end
   endtask

   task automatic test_reset();
      bit bad;
      rst_n = 1'b0;
      ena = 2'b00;
      for (int k = 0; k < 8; k++) begin
         ena = 2'($urandom);
         if ($urandom_range(0, 1) == 1) q0.push_back(4'($urandom));
         if ($urandom_range(0, 1) == 1) q1.push_back(4'($urandom));
         tick();
         n_tests++;
         if (tx_out !== 2'b11 || rd_en !== 2'b00 || busy !== 2'b00 || tx_done !== 2'b00 ||
             wc_out0 !== 8'd0 || wc_out1 !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_hold: tx_out=%b rd_en=%b busy=%b tx_done=%b wc=%0d/%0d, required 11/00/00/00/0/0",
                     tx_out, rd_en, busy, tx_done, wc_out0, wc_out1);
         end
      end
      q0.delete();
      q1.delete();
      tick();
      tick();
      rst_n = 1'b1;
      ena = 2'b11;
      wc_exp[0] = 0;
      wc_exp[1] = 0;
      bad = 0;
      for (int k = 0; k < 10; k++) begin
         tick();
         if (tx_out !== 2'b11 || rd_en !== 2'b00 || busy !== 2'b00 || tx_done !== 2'b00) bad = 1;
      end
      n_tests++;
      if (bad) begin
         n_fail++;
         $display("FAIL reset_release: tx_out=%b rd_en=%b busy=%b, required idle 11/00/00", tx_out, rd_en, busy);
      end
   endtask

   task automatic test_single();
      int r0, tf, td;
      r0 = rd_cnt[0];
      ena[0] = 1'b1;
      q0.push_back(4'b1010);
      check_frame(0, 4'b1010, "single", -1, tf, td);
      n_tests++;
      if (rd_cnt[0] - r0 != 1 || rd_dbl[0] != 0 || rd_cyc[0] - empty_low[0] != 1) begin
         n_fail++;
         $display("FAIL single_pop: pops=%0d wide=%0d pop_delay=%0d, required 1/0/1",
                  rd_cnt[0] - r0, rd_dbl[0], rd_cyc[0] - empty_low[0]);
      end
      n_tests++;
      if (tf - empty_low[0] != 3) begin
         n_fail++;
         $display("FAIL single_latency: tx_out fell %0d edges after empty low, required 3", tf - empty_low[0]);
      end
   endtask

   task automatic test_back_to_back();
      int r0, tf1, td1, tf2, td2;
      r0 = rd_cnt[0];
      ena[0] = 1'b1;
      q0.push_back(4'b1100);
      q0.push_back(4'b0011);
      check_frame(0, 4'b1100, "b2b_first", -1, tf1, td1);
      check_frame(0, 4'b0011, "b2b_second", -1, tf2, td2);
      n_tests++;
      if (rd_cnt[0] - r0 != 2 || rd_dbl[0] != 0 || rd_cyc[0] != td1 + 1) begin
         n_fail++;
         $display("FAIL b2b_pops: pops=%0d wide=%0d second_pop_at=%0d, required 2/0/%0d",
                  rd_cnt[0] - r0, rd_dbl[0], rd_cyc[0], td1 + 1);
      end
      n_tests++;
      if (tf2 - td1 != 3) begin
         n_fail++;
         $display("FAIL b2b_gap: second start %0d cycles after tx_done, required 3", tf2 - td1);
      end
   endtask

   task automatic test_enable();
      int r0, tf, td;
      bit bad;
      logic [3:0] wa, wb;
      wa = 4'($urandom);
      wb = 4'($urandom);
      ena[0] = 1'b0;
      r0 = rd_cnt[0];
      q0.push_back(wa);
      q0.push_back(wb);
      bad = 0;
      for (int k = 0; k < 50; k++) begin
         tick();
         if (tx_out[0] !== 1'b1 || rd_en[0] !== 1'b0 || busy[0] !== 1'b0) bad = 1;
      end
      n_tests++;
      if (bad || rd_cnt[0] != r0) begin
         n_fail++;
         $display("FAIL ena_low: pops=%0d tx_out=%b, required no pop and line high", rd_cnt[0] - r0, tx_out[0]);
      end
      ena[0] = 1'b1;
      check_frame(0, wa, "ena_drop", 2 * C + 1, tf, td);
      repeat (30) tick();
      n_tests++;
      if (rd_cnt[0] - r0 != 1 || q0.size() != 1 || tx_out[0] !== 1'b1) begin
         n_fail++;
         $display("FAIL ena_drop_pops: pops=%0d left=%0d tx_out=%b, required 1/1/1",
                  rd_cnt[0] - r0, q0.size(), tx_out[0]);
      end
      ena[0] = 1'b1;
      check_frame(0, wb, "ena_resume", -1, tf, td);
   endtask

   task automatic test_reset_mid_frame();
      bit seen;
      int tf, td;
      ena[0] = 1'b1;
      q0.push_back(4'b1101);
      seen = 0;
      for (int k = 0; k < 50 && !seen; k++) begin
         tick();
         if (tx_out[0] === 1'b0) seen = 1;
      end
      repeat (2 * C + 1) tick();
      n_tests++;
      if (!seen || tx_out[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL midrst_pre: tx_out=%b in 2nd data bit, required 0", tx_out[0]);
      end
      rst_n = 1'b0;
      #1;
      wc_exp[0] = 0;
      wc_exp[1] = 0;
      n_tests++;
      if (tx_out[0] !== 1'b1 || wc_out0 !== 8'd0 || busy[0] !== 1'b0 || rd_en[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL midrst_async: tx_out=%b word_count=%0d busy=%b, required 1/0/0",
                  tx_out[0], wc_out0, busy[0]);
      end
      repeat (3) tick();
      rst_n = 1'b1;
      tick();
      q0.push_back(4'b0101);
      check_frame(0, 4'b0101, "midrst_after", -1, tf, td);
   endtask

   task automatic test_parity();
      int tf, td;
      ena[1] = 1'b1;
      q1.push_back(4'b0111);
      check_frame(1, 4'b0111, "parity", -1, tf, td);
      n_tests++;
      if (td - tf != 7 * C) begin
         n_fail++;
         $display("FAIL parity_len: frame %0d cycles, required %0d", td - tf, 7 * C);
      end
   endtask

   // Random words on both instances; instance 1 passes its counter wrap here.
   task automatic test_random();
      int tf, td;
      logic [3:0] w;
      ena = 2'b11;
      for (int n = 0; n < 8; n++) begin
         w = 4'($urandom);
         repeat ($urandom_range(0, 5)) tick();
         if (n % 2 == 0) q0.push_back(w);
         else q1.push_back(w);
         check_frame(n % 2, w, (n % 2 == 0) ? "rand_plain" : "rand_parity", -1, tf, td);
      end
      begin
         logic [3:0] burst[3];
         for (int n = 0; n < 3; n++) begin
            burst[n] = 4'($urandom);
            q0.push_back(burst[n]);
         end
         for (int n = 0; n < 3; n++) check_frame(0, burst[n], "rand_burst", -1, tf, td);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      ena = 2'b00;
      test_reset();
      test_single();
      test_back_to_back();
      test_enable();
      test_reset_mid_frame();
      test_parity();
      test_random();
      repeat (5) tick();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/fifo_drain_serializer.md
Name: fifo_drain_serializer

Overview:
- Read-side companion to the team's 4-bit synchronous FIFO: pops one word at a time through the FIFO read port and shifts it out on a single-wire, UART-style serial line.
- Sits between the FIFO read interface (read enable, read data, empty flag) and a chip output pin.
- Provides frame status (busy, done) and a running count of transmitted words.

Parameters:
- DATA_W, 4, width of each FIFO word and of each serial data field.
- CLKS_PER_BIT, 4, clk cycles per serial bit; must be >= 1.
- PARITY_EN, 0, 1 inserts an even-parity bit between the data bits and the stop bit.
- CNT_W, 8, width of word_count.

Ports:
- clk  input  1  system clock, all state changes on the rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- ena  input  1  enable; sampled only in IDLE.
- fifo_empty  input  1  FIFO empty flag.
- fifo_rd_data  input  DATA_W  FIFO read data; valid the cycle after fifo_rd_en is high.
- fifo_rd_en  output  1  FIFO pop strobe; high for exactly one cycle per word.
- tx_out  output  1  serial line; idles high. Registered.
- busy  output  1  high in every state except IDLE.
- tx_done  output  1  one-cycle pulse after each stop bit completes.
- word_count  output  CNT_W  number of completed frames; wraps modulo 2^CNT_W.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-frame):
  - tx_out=1, fifo_rd_en=0, busy=0, tx_done=0, word_count=0.
  - State=IDLE; bit counter, divider and shift register cleared.
- FSM states: IDLE, POP, WAIT, START, DATA, PARITY, STOP.
- IDLE:
  - If ena=1 and fifo_empty=0 at an edge -> POP; otherwise stay in IDLE.
  - fifo_empty and ena are ignored in every other state.
- POP: fifo_rd_en=1 for this single cycle only -> WAIT.
- WAIT: on the edge leaving WAIT, capture fifo_rd_data into the shift register, set tx_out=0 and enter START.
- START: tx_out=0 for CLKS_PER_BIT cycles -> DATA.
- DATA:
  - Shift out DATA_W bits, LSB first, each held CLKS_PER_BIT cycles.
  - tx_out updates on the same edge that begins each bit.
  - Exit to PARITY if PARITY_EN=1, else to STOP.
- PARITY: tx_out = XOR of the captured word (even parity) for CLKS_PER_BIT cycles -> STOP.
- STOP:
  - tx_out=1 for CLKS_PER_BIT cycles.
  - On the closing edge: go to IDLE, set tx_done=1 for that one IDLE cycle, increment word_count.
- Bit timing: a divider counts 0..CLKS_PER_BIT-1 and resets at each bit boundary. With CLKS_PER_BIT=1, every bit lasts one cycle.
- Latency and frame length:
  - From an edge sampling fifo_empty=0 in IDLE to tx_out falling: 3 edges.
  - From tx_out falling to tx_done rising: (DATA_W+2+PARITY_EN)*CLKS_PER_BIT cycles.
- Back-to-back words: the IDLE cycle carrying tx_done may start the next pop. The minimum line-high gap between frames is therefore one stop bit plus 3 cycles.
- ena deasserted mid-frame: the frame completes normally; no new pop until ena=1 in IDLE.
- fifo_empty rising after POP: ignored; the captured word is transmitted.
- word_count at its maximum value: wraps to 0 on the next completed frame.
- Reset mid-frame: the partial frame is abandoned, word_count is not incremented, and the next frame starts cleanly with a full start bit.

Test Plan:
1. Reset check: hold rst_n=0 and drive random inputs -> tx_out=1, fifo_rd_en=0, busy=0, tx_done=0, word_count=0. Release rst_n with fifo_empty=1 -> outputs stay at idle.
2. Single word (DATA_W=4, CLKS_PER_BIT=4, PARITY_EN=0), FIFO word 4'b1010, fifo_empty falls, ena=1:
   - fifo_rd_en is one 1-cycle pulse.
   - tx_out falls 3 edges after empty is sampled low.
   - tx_out sequence 0,0,1,0,1,1, each bit 4 cycles.
   - tx_done pulses 24 cycles after tx_out falls; word_count=1.
3. Back-to-back words 4'b1100 then 4'b0011 with fifo_empty held low:
   - Exactly two fifo_rd_en pulses; the second occurs in the cycle after tx_done.
   - Bit sequences 0,0,0,1,1,1 then 0,1,1,0,0,1.
   - word_count=2.
4. Enable gating:
   - ena=0 with fifo_empty=0 for 50 cycles -> no fifo_rd_en and tx_out stays 1.
   - Drop ena during the DATA bits of a frame -> the frame completes and tx_done pulses, but no further pop.
5. Reset mid-frame: assert rst_n=0 during the 2nd data bit -> tx_out=1 immediately and word_count=0. After release, a new word 4'b0101 transmits a full, correct frame.
6. Parity (PARITY_EN=1), word 4'b0111:
   - tx_out sequence 0,1,1,1,0,1,1 (parity bit = 1).
   - Frame length is 28 cycles; word_count increments by 1.
